// File: rtl/acl2_pkg.sv
// acl2_pkg: ACL2 command/register constants, scheduler state encoding and
// per-state byte helpers shared by the sample scheduler.
`default_nettype none

package acl2_pkg;

   localparam logic [7:0] ACL2_WRITE     = 8'h0A;
   localparam logic [7:0] ACL2_READ      = 8'h0B;
   localparam logic [7:0] ACL2_POWER_CTL = 8'h2D;
   localparam logic [7:0] ACL2_XDATA     = 8'h08;
   localparam logic [7:0] ACL2_MEASURE   = 8'h02;

   typedef enum logic [3:0] {
      ST_STARTUP   = 4'd0,
      ST_CFG_CMD   = 4'd1,
      ST_CFG_ADDR  = 4'd2,
      ST_CFG_DATA  = 4'd3,
      ST_WAIT_TICK = 4'd4,
      ST_RD_CMD    = 4'd5,
      ST_RD_ADDR   = 4'd6,
      ST_RD_X      = 4'd7,
      ST_RD_Y      = 4'd8,
      ST_RD_Z      = 4'd9
   } state_t;

   function automatic logic is_byte_state(state_t s);
      return (s != ST_STARTUP) && (s != ST_WAIT_TICK);
   endfunction

   function automatic logic [7:0] state_tx(state_t s);
      case (s)
         ST_CFG_CMD:  return ACL2_WRITE;
         ST_CFG_ADDR: return ACL2_POWER_CTL;
         ST_CFG_DATA: return ACL2_MEASURE;
         ST_RD_CMD:   return ACL2_READ;
         ST_RD_ADDR:  return ACL2_XDATA;
         default:     return 8'h00;
      endcase
   endfunction

   // Only the last byte of each transaction releases chip select.
   function automatic logic state_hold(state_t s);
      return (s != ST_CFG_DATA) && (s != ST_RD_Z);
   endfunction

   function automatic state_t next_byte_state(state_t s);
      case (s)
         ST_CFG_CMD:  return ST_CFG_ADDR;
         ST_CFG_ADDR: return ST_CFG_DATA;
         ST_CFG_DATA: return ST_WAIT_TICK;
         ST_RD_CMD:   return ST_RD_ADDR;
         ST_RD_ADDR:  return ST_RD_X;
         ST_RD_X:     return ST_RD_Y;
         ST_RD_Y:     return ST_RD_Z;
         ST_RD_Z:     return ST_WAIT_TICK;
         default:     return ST_STARTUP;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/acl2_sample_scheduler_tick_gen.sv
// acl2_tick_gen: sample-period ticker with a one-deep pending flag and
// sticky overrun detection. Counting restarts whenever enable is low.
`default_nettype none

module acl2_tick_gen #(
   parameter logic [23:0] SAMPLE_PERIOD = 24'd1250000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic consume,
   input  logic clear,
   output logic pending,
   output logic overrun
);

   logic [23:0] count;
   logic        tick;

   assign tick = enable && (count == SAMPLE_PERIOD - 24'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (!enable || tick) count <= '0;
         else                 count <= count + 24'd1;

         // A tick landing on the consume cycle refills the flag without loss.
         if (clear) begin
            pending <= 1'b0;
         end else begin
            pending <= tick | (pending & ~consume);
            if (tick && pending && !consume) overrun <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/acl2_sample_scheduler.sv
// acl2_sample_scheduler: drives a byte-level SPI engine to configure the ACL2
// for measurement, then bursts X/Y/Z reads on every sample tick.
`default_nettype none

module acl2_sample_scheduler
   import acl2_pkg::*;
#(
   parameter logic [15:0] STARTUP_CYCLES = 16'd12500,
   parameter logic [23:0] SAMPLE_PERIOD  = 24'd1250000,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       XFER_READY,
   output logic       XFER_START,
   output logic [7:0] XFER_TX,
   output logic       XFER_HOLD_CS,
   input  logic       XFER_DONE,
   input  logic [7:0] XFER_RX,
   input  logic [1:0] AXIS_SEL,
   output logic [7:0] X_DATA,
   output logic [7:0] Y_DATA,
   output logic [7:0] Z_DATA,
   output logic [7:0] DATA_OUT,
   output logic       SAMPLE_VALID,
   output logic       DONE_SETUP,
   output logic       OVERRUN,
   output logic       ERR
);

   state_t      state, state_next;
   logic        waiting;
   logic [15:0] startup_cnt;
   logic [15:0] timer;
   logic [7:0]  shadow_x, shadow_y;
   logic        startup_done;
   logic        launch, accept, timeout, consume;
   logic        pending;

   assign startup_done = ({1'b0, startup_cnt} + 17'd1) >= {1'b0, STARTUP_CYCLES};

   acl2_tick_gen #(
      .SAMPLE_PERIOD (SAMPLE_PERIOD)
   ) u_tick_gen (
      .clk     (CLK),
      .rst     (RESET),
      .enable  (DONE_SETUP),
      .consume (consume),
      .clear   (timeout),
      .pending (pending),
      .overrun (OVERRUN)
   );

   // Each byte state has a launch phase (waiting = 0) and a completion phase.
   always_comb begin
      state_next = state;
      launch     = 1'b0;
      accept     = 1'b0;
      timeout    = 1'b0;
      consume    = 1'b0;
      if (is_byte_state(state)) begin
         if (!waiting)                                launch  = XFER_READY;
         else if (XFER_DONE)                          accept  = 1'b1;
         else if (timer == TIMEOUT_CYCLES - 16'd1)    timeout = 1'b1;
      end
      case (state)
         ST_STARTUP:   if (startup_done) state_next = ST_CFG_CMD;
         ST_WAIT_TICK: if (pending) begin
                          consume    = 1'b1;
                          state_next = ST_RD_CMD;
                       end
         default: begin
            if (accept)       state_next = next_byte_state(state);
            else if (timeout) state_next = ST_STARTUP;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= ST_STARTUP;
         waiting      <= 1'b0;
         startup_cnt  <= '0;
         timer        <= '0;
         XFER_START   <= 1'b0;
         XFER_TX      <= 8'h00;
         XFER_HOLD_CS <= 1'b0;
         shadow_x     <= 8'h00;
         shadow_y     <= 8'h00;
         X_DATA       <= 8'h00;
         Y_DATA       <= 8'h00;
         Z_DATA       <= 8'h00;
         DATA_OUT     <= 8'h00;
         SAMPLE_VALID <= 1'b0;
         DONE_SETUP   <= 1'b0;
         ERR          <= 1'b0;
      end else begin
         state        <= state_next;
         XFER_START   <= launch;
         SAMPLE_VALID <= accept && (state == ST_RD_Z);

         if (launch) begin
            waiting      <= 1'b1;
            timer        <= '0;
            XFER_TX      <= state_tx(state);
            XFER_HOLD_CS <= state_hold(state);
         end else if (accept || timeout) begin
            waiting <= 1'b0;
         end else if (waiting) begin
            timer <= timer + 16'd1;
         end

         if (timeout) begin
            XFER_HOLD_CS <= 1'b0;
            ERR          <= 1'b1;
            DONE_SETUP   <= 1'b0;
         end

         if (state == ST_STARTUP && !startup_done) startup_cnt <= startup_cnt + 16'd1;
         else                                      startup_cnt <= '0;

         // Z goes straight to the output so all three axes update together.
         if (accept) begin
            case (state)
               ST_CFG_DATA: DONE_SETUP <= 1'b1;
               ST_RD_X:     shadow_x   <= XFER_RX;
               ST_RD_Y:     shadow_y   <= XFER_RX;
               ST_RD_Z: begin
                  X_DATA <= shadow_x;
                  Y_DATA <= shadow_y;
                  Z_DATA <= XFER_RX;
               end
               default: ;
            endcase
         end

         case (AXIS_SEL)
            2'd0: DATA_OUT <= X_DATA;
            2'd1: DATA_OUT <= Y_DATA;
            2'd2: DATA_OUT <= Z_DATA;
            2'd3: DATA_OUT <= 8'h00;
         endcase
      end
   end

endmodule

`default_nettype wire
